// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM states, SRAM geometry, address mapping.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sram_ctrl_pkg;

    localparam int          SRAM_AW       = 18;
    localparam int          SRAM_DW       = 16;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    // Upper SRAM_AW-1 bits of the half-word address, i.e. ((addr - base) >> 1)[17:1].
    // The half-word select bit is supplied by the FSM, so only the pair index is kept.
    // Out-of-range addresses wrap silently.
    function automatic logic [SRAM_AW-2:0] pair_addr(input logic [31:0] byte_addr,
                                                     input logic [31:0] base);
        return (SRAM_AW-1)'((byte_addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side request/response bundle of the SRAM controller.
// Latency: n/a (wiring only).
// Backpressure: ready low tells the pipeline to freeze and hold its request.
// Signals: wr_en/rd_en held requests, addr byte address, wdata store data,
//          rdata load result, ready access complete or no request.
interface sram_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Dwell counter for one SRAM half-access; tc marks the last cycle of the half.
// Latency: tc is combinational from the count; count updates on the next edge.
// Backpressure: none; clr takes priority over en.
// Ports: clk, rst (async active-low), clr, en, tc (count == WAIT_CYCLES).
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [2:0] TC_VAL = 3'(WAIT_CYCLES);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 3'd0;
        end else if (clr) begin
            cnt <= 3'd0;
        end else if (en) begin
            cnt <= cnt + 3'd1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/sram_ctrl.sv
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two half accesses.
// Latency: 2*(WAIT_CYCLES+1)+1 stall cycles per access; ready rises in the DONE cycle.
// Backpressure: ready low while a request is outstanding; the pipeline holds its request.
// Ports: clk, rst (async active-low), bus (sram_ctrl_if.slave),
//        sram_addr half-word address, sram_dq bidirectional data, sram_we_n write strobe.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_if.slave         bus,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n
);

    state_t             state;
    logic [SRAM_AW-2:0] pair_q;
    logic [31:0]        wdata_q;
    logic               is_wr_q;
    logic               half_q;
    logic               dq_oe_q;
    logic               we_n_q;
    logic [31:0]        rdata_q;

    logic req;
    logic cnt_en;
    logic cnt_clr;
    logic tc;

    assign req = bus.wr_en | bus.rd_en;

    // Count only inside a half; clearing everywhere else and on the terminal
    // cycle guarantees a fresh count on every state entry.
    assign cnt_en  = (state == LO) || (state == HI);
    assign cnt_clr = !cnt_en || tc;

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    // ready is combinational so an idle pipeline is never stalled and the DONE
    // cycle releases the freeze without an extra registered bubble.
    assign bus.ready = !req || (state == DONE);
    assign bus.rdata = rdata_q;

    assign sram_addr = {pair_q, half_q};
    assign sram_we_n = we_n_q;
    assign sram_dq   = dq_oe_q ? (half_q ? wdata_q[31:16] : wdata_q[15:0]) : {SRAM_DW{1'bz}};

    // Strobe and bus-enable are registered alongside the state, so they are
    // glitch-free and exactly cover LO and HI. Reset drops them at once, which
    // abandons any write in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pair_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            half_q  <= 1'b0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // A simultaneous read+write request is served as a write.
                        pair_q  <= pair_addr(bus.addr, BASE_ADDR);
                        wdata_q <= bus.wdata;
                        is_wr_q <= bus.wr_en;
                        half_q  <= 1'b0;
                        we_n_q  <= !bus.wr_en;
                        dq_oe_q <= bus.wr_en;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (tc) begin
                        if (!is_wr_q) begin
                            rdata_q[15:0] <= sram_dq;
                        end
                        half_q <= 1'b1;
                        state  <= HI;
                    end
                end
                HI: begin
                    if (tc) begin
                        if (!is_wr_q) begin
                            rdata_q[31:16] <= sram_dq;
                        end
                        half_q  <= 1'b0;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Never chain directly into a new access: a request still
                    // high here is the one just completed.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0,
// each attached to a small behavioural SRAM that drives the bus whenever sram_we_n is high.
// Inputs change and outputs are sampled 1 time unit after the falling clock edge.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic mem_init;

    int checks;
    int failures;

    sram_ctrl_if bus1 ();
    sram_ctrl_if bus0 ();

    logic [17:0] sram_addr1;
    wire  [15:0] sram_dq1;
    logic        sram_we_n1;
    logic [17:0] sram_addr0;
    wire  [15:0] sram_dq0;
    logic        sram_we_n0;

    logic [15:0] mem1 [0:7];
    logic [15:0] mem0 [0:7];

    sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .sram_addr (sram_addr1),
        .sram_dq   (sram_dq1),
        .sram_we_n (sram_we_n1)
    );

    sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0),
        .sram_addr (sram_addr0),
        .sram_dq   (sram_dq0),
        .sram_we_n (sram_we_n0)
    );

    // SRAM models: output enabled whenever not writing, write captured on the clock.
    assign sram_dq1 = sram_we_n1 ? mem1[sram_addr1[2:0]] : 16'hzzzz;
    assign sram_dq0 = sram_we_n0 ? mem0[sram_addr0[2:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_init) begin
            mem1[0] <= 16'h0F0F; mem1[1] <= 16'h0000; mem1[2] <= 16'hBEEF; mem1[3] <= 16'hDEAD;
            mem1[4] <= 16'h0000; mem1[5] <= 16'h0000; mem1[6] <= 16'h0000; mem1[7] <= 16'h7777;
            mem0[0] <= 16'h0000; mem0[1] <= 16'h0000; mem0[2] <= 16'h1111; mem0[3] <= 16'h2222;
            mem0[4] <= 16'h3333; mem0[5] <= 16'h4444; mem0[6] <= 16'h0000; mem0[7] <= 16'h0000;
        end else begin
            if (!sram_we_n1) mem1[sram_addr1[2:0]] <= sram_dq1;
            if (!sram_we_n0) mem0[sram_addr0[2:0]] <= sram_dq0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-access observations of u_dut1, filled by access1.
    int          stall;
    int          we_low;
    logic        done_seen;
    logic [31:0] rdata_done;
    logic [17:0] alog [$];
    logic [15:0] dlog [$];

    // Presents one held request to u_dut1 until ready rises (bounded), logging
    // every stalled cycle after the first, then drops the request.
    task automatic access1(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        alog.delete();
        dlog.delete();
        stall      = 0;
        we_low     = 0;
        done_seen  = 1'b0;
        rdata_done = '0;
        @(negedge clk);
        bus1.wr_en = w;
        bus1.rd_en = r;
        bus1.addr  = a;
        bus1.wdata = d;
        #1;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            if (!sram_we_n1) we_low++;
            if (!bus1.ready) begin
                stall++;
                if (i > 0) begin
                    alog.push_back(sram_addr1);
                    dlog.push_back(sram_dq1);
                end
            end else begin
                done_seen  = 1'b1;
                rdata_done = bus1.rdata;
            end
            if (!done_seen) begin
                @(negedge clk);
                #1;
            end
        end
        @(negedge clk);
        bus1.wr_en = 1'b0;
        bus1.rd_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (bus1.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus1.ready); end
        checks++; if (sram_we_n1 !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n1); end
        checks++; if (bus1.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus1.rdata); end
        checks++; if (sram_addr1 !== 18'd0) begin failures++; $display("FAIL reset_sram_addr got=%0d exp=0", sram_addr1); end
        checks++; if (sram_dq1 !== 16'h0F0F) begin failures++; $display("FAIL reset_dq_released got=%h exp=0f0f", sram_dq1); end
        checks++; if (bus0.ready !== 1'b1) begin failures++; $display("FAIL reset_ready_w0 got=%b exp=1", bus0.ready); end
        checks++; if (sram_we_n0 !== 1'b1) begin failures++; $display("FAIL reset_we_n_w0 got=%b exp=1", sram_we_n0); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load();
        logic [17:0] ea [4];
        logic [15:0] ed [4];
        ea = '{18'd2, 18'd2, 18'd3, 18'd3};
        ed = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
        // wdata of all ones makes any stray drive during a read or idle visible.
        access1(1'b0, 1'b1, 32'd1028, 32'hFFFF_FFFF);
        checks++; if (stall !== 5) begin failures++; $display("FAIL load_stall got=%0d exp=5", stall); end
        checks++; if (we_low !== 0) begin failures++; $display("FAIL load_we_low got=%0d exp=0", we_low); end
        checks++; if (rdata_done !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata_done); end
        checks++;
        if (alog.size() != 4) begin
            failures++; $display("FAIL load_addr_count got=%0d exp=4", alog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (alog[k] !== ea[k]) begin failures++; $display("FAIL load_addr[%0d] got=%0d exp=%0d", k, alog[k], ea[k]); end
                checks++; if (dlog[k] !== ed[k]) begin failures++; $display("FAIL load_dq[%0d] got=%h exp=%h", k, dlog[k], ed[k]); end
            end
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus1.ready !== 1'b1) begin failures++; $display("FAIL idle_ready[%0d] got=%b exp=1", i, bus1.ready); end
            checks++; if (sram_we_n1 !== 1'b1) begin failures++; $display("FAIL idle_we_n[%0d] got=%b exp=1", i, sram_we_n1); end
            checks++; if (sram_addr1 !== 18'd2) begin failures++; $display("FAIL idle_addr[%0d] got=%0d exp=2", i, sram_addr1); end
            checks++; if (sram_dq1 !== 16'hBEEF) begin failures++; $display("FAIL idle_dq[%0d] got=%h exp=beef", i, sram_dq1); end
        end
    endtask

    task automatic test_store();
        logic [17:0] ea [4];
        logic [15:0] ed [4];
        ea = '{18'd0, 18'd0, 18'd1, 18'd1};
        ed = '{16'h5678, 16'h5678, 16'h1234, 16'h1234};
        access1(1'b1, 1'b0, 32'd1024, 32'h1234_5678);
        checks++; if (stall !== 5) begin failures++; $display("FAIL store_stall got=%0d exp=5", stall); end
        checks++; if (we_low !== 4) begin failures++; $display("FAIL store_we_low got=%0d exp=4", we_low); end
        checks++; if (rdata_done !== 32'hDEADBEEF) begin failures++; $display("FAIL store_rdata got=%h exp=deadbeef", rdata_done); end
        checks++; if (mem1[0] !== 16'h5678) begin failures++; $display("FAIL store_mem0 got=%h exp=5678", mem1[0]); end
        checks++; if (mem1[1] !== 16'h1234) begin failures++; $display("FAIL store_mem1 got=%h exp=1234", mem1[1]); end
        checks++;
        if (alog.size() != 4) begin
            failures++; $display("FAIL store_addr_count got=%0d exp=4", alog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (alog[k] !== ea[k]) begin failures++; $display("FAIL store_addr[%0d] got=%0d exp=%0d", k, alog[k], ea[k]); end
                checks++; if (dlog[k] !== ed[k]) begin failures++; $display("FAIL store_dq[%0d] got=%h exp=%h", k, dlog[k], ed[k]); end
            end
        end
    endtask

    task automatic test_both();
        access1(1'b1, 1'b1, 32'd1032, 32'hA5A5_A5A5);
        checks++; if (stall !== 5) begin failures++; $display("FAIL both_stall got=%0d exp=5", stall); end
        checks++; if (we_low !== 4) begin failures++; $display("FAIL both_we_low got=%0d exp=4", we_low); end
        checks++; if (rdata_done !== 32'hDEADBEEF) begin failures++; $display("FAIL both_rdata got=%h exp=deadbeef", rdata_done); end
        checks++; if (mem1[4] !== 16'hA5A5) begin failures++; $display("FAIL both_mem4 got=%h exp=a5a5", mem1[4]); end
        checks++; if (mem1[5] !== 16'hA5A5) begin failures++; $display("FAIL both_mem5 got=%h exp=a5a5", mem1[5]); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus1.wr_en = 1'b1;
        bus1.rd_en = 1'b0;
        bus1.addr  = 32'd1036;
        bus1.wdata = 32'hCAFE_F00D;
        // IDLE, LO, LO, then the first HI cycle.
        repeat (3) @(negedge clk);
        #1;
        checks++; if (sram_we_n1 !== 1'b0) begin failures++; $display("FAIL rmid_hi_we_n got=%b exp=0", sram_we_n1); end
        checks++; if (sram_addr1 !== 18'd7) begin failures++; $display("FAIL rmid_hi_addr got=%0d exp=7", sram_addr1); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (sram_we_n1 !== 1'b1) begin failures++; $display("FAIL rmid_we_n got=%b exp=1", sram_we_n1); end
        checks++; if (bus1.rdata !== 32'h0) begin failures++; $display("FAIL rmid_rdata got=%h exp=0", bus1.rdata); end
        checks++; if (sram_addr1 !== 18'd0) begin failures++; $display("FAIL rmid_addr got=%0d exp=0", sram_addr1); end
        @(negedge clk);
        bus1.wr_en = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus1.ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", bus1.ready); end
        checks++; if (mem1[7] !== 16'h7777) begin failures++; $display("FAIL rmid_no_hi_write got=%h exp=7777", mem1[7]); end
        access1(1'b0, 1'b1, 32'd1028, 32'h0);
        checks++; if (stall !== 5) begin failures++; $display("FAIL rmid_load_stall got=%0d exp=5", stall); end
        checks++; if (rdata_done !== 32'hDEADBEEF) begin failures++; $display("FAIL rmid_load_rdata got=%h exp=deadbeef", rdata_done); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  trace;
        logic [31:0] rd_a;
        logic [31:0] rd_b;
        trace = '0;
        rd_a  = '0;
        rd_b  = '0;
        @(negedge clk);
        bus0.rd_en = 1'b1;
        bus0.addr  = 32'd1028;
        #1;
        for (int i = 0; i < 8; i++) begin
            trace = {trace[6:0], bus0.ready};
            if (i == 3) begin
                rd_a      = bus0.rdata;
                bus0.addr = 32'd1032;
            end
            if (i == 7) rd_b = bus0.rdata;
            @(negedge clk);
            #1;
        end
        bus0.rd_en = 1'b0;
        #1;
        checks++; if (trace !== 8'b0001_0001) begin failures++; $display("FAIL b2b_ready_trace got=%b exp=00010001", trace); end
        checks++; if (rd_a !== 32'h2222_1111) begin failures++; $display("FAIL b2b_rdata_a got=%h exp=22221111", rd_a); end
        checks++; if (rd_b !== 32'h4444_3333) begin failures++; $display("FAIL b2b_rdata_b got=%h exp=44443333", rd_b); end
        checks++; if (bus0.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after got=%b exp=1", bus0.ready); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        mem_init   = 1'b1;
        bus1.wr_en = 1'b0;
        bus1.rd_en = 1'b0;
        bus1.addr  = '0;
        bus1.wdata = '0;
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        bus0.addr  = '0;
        bus0.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;

        test_reset();
        test_load();
        test_idle();
        test_store();
        test_both();
        test_reset_mid();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
